// File: rtl/glb_4094_sequencer.sv
// ---------------------------------------------------------------------------
// glb_4094_sequencer
//
// Autonomous shifter for the GLB 4094 shift-register chain. A parallel word
// is serialised MSB-first onto g4094_clk/g4094_data. Once the last bit has
// been clocked in, g4094_strb is pulsed so the 4094 storage latches take the
// new word. g4094_oe is held low until the first complete update after reset.
// This keeps the chain outputs from driving power-up garbage.
//
// Request handshake (start/busy/done):
//   - A start seen while idle is accepted on that clock edge. data is
//     sampled on that edge only, and busy rises on the same edge.
//   - A start seen while busy (FIN included) is not dropped. Its data goes
//     into a single pending slot, and the latest request wins. The pending
//     word is launched on the edge leaving FIN, so busy never drops.
//   - done pulses for exactly one cycle (FIN) per completed transfer.
//   - A reset mid-transfer aborts it without a strobe, so the 4094 latches
//     keep their previous contents.
//
// Parameters:
//   NBITS          chain length in bits (2..64)
//   CLK_DIV        4094 clock half-period in clk cycles (>=1)
//   STROBE_CYCLES  strobe high time in clk cycles (>=1)
//
// Optional feature, macro GLB_4094_READBACK_EN:
//   miso is sampled at the end of every low phase of g4094_clk and collected
//   into rb_data. mismatch flags when the readback differs from the previously
//   written word. Without the macro, rb_data and mismatch are tied to 0 and
//   miso is ignored.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request an update using data
//   data        in   word to load, bit NBITS-1 shifted first
//   oe_en       in   requested output-enable state
//   miso        in   chain serial output
//   busy        out  transfer in progress
//   done        out  one-cycle pulse at transfer completion
//   g4094_clk   out  chain shift clock
//   g4094_data  out  chain serial data
//   g4094_strb  out  chain strobe, active high
//   g4094_oe    out  chain output enable, active high
//   rb_data     out  word read back from the chain
//   mismatch    out  readback differs from previous written word
//   dbg_state   out  current FSM state encoding (state_t)
// ---------------------------------------------------------------------------
module glb_4094_sequencer #(
  parameter int NBITS         = 24,
  parameter int CLK_DIV       = 4,
  parameter int STROBE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] data,
  input  logic             oe_en,
  input  logic             miso,
  output logic             busy,
  output logic             done,
  output logic             g4094_clk,
  output logic             g4094_data,
  output logic             g4094_strb,
  output logic             g4094_oe,
  output logic [NBITS-1:0] rb_data,
  output logic             mismatch,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_LO = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_STROBE   = 3'd3,
    S_FIN      = 3'd4
  } state_t;

  localparam int CMAX = (CLK_DIV > STROBE_CYCLES) ? CLK_DIV : STROBE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NBITS);

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] sh_reg;
  logic [NBITS-1:0] pend_data;
  logic             pend;
  logic             first_done;
  logic             oe_q;
  logic             cnt_last;
  logic             accept;
  logic [NBITS-1:0] load_word;

  // Last cycle of the timed phase the FSM is currently in.
  always_comb begin
    cnt_last = 1'b0;
    case (state)
      S_SHIFT_LO, S_SHIFT_HI: cnt_last = (cnt == DIV_LAST);
      S_STROBE:               cnt_last = (cnt == STB_LAST);
      default:                cnt_last = 1'b0;
    endcase
  end

  // Next-state logic. accept marks the edge on which a word is loaded into
  // the shifter, either a fresh start from IDLE or a back-to-back restart at
  // FIN. A start coincident with FIN is newer than the pending slot, so it
  // takes priority.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    load_word = data;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (cnt_last) state_nx = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (cnt_last) state_nx = (bit_cnt == BIT_LAST) ? S_STROBE : S_SHIFT_LO;
      end
      S_STROBE: begin
        if (cnt_last) state_nx = S_FIN;
      end
      S_FIN: begin
        if (start || pend) begin
          accept    = 1'b1;
          load_word = start ? data : pend_data;
          state_nx  = S_SHIFT_LO;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      sh_reg     <= '0;
      pend_data  <= '0;
      pend       <= 1'b0;
      first_done <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      // Phase timer restarts on every state change.
      if (state_nx != state || state == S_IDLE) cnt <= '0;
      else                                      cnt <= cnt + CW'(1);

      if (accept) begin
        bit_cnt <= '0;
        sh_reg  <= load_word;
      end else if (state == S_SHIFT_HI && state_nx == S_SHIFT_LO) begin
        // Advancing here changes g4094_data only on entry to SHIFT_LO, a
        // full half-period after the chain's rising-edge sample.
        bit_cnt <= bit_cnt + BW'(1);
        sh_reg  <= {sh_reg[NBITS-2:0], 1'b0};
      end

      if (state == S_FIN && accept) begin
        pend <= 1'b0;
      end else if (start && state != S_IDLE) begin
        pend      <= 1'b1;
        pend_data <= data;
      end

      if (state == S_FIN) first_done <= 1'b1;

      // Include FIN itself so the enable follows done by exactly one cycle.
      oe_q <= (first_done | (state == S_FIN)) & oe_en;
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);
  assign g4094_clk  = (state == S_SHIFT_HI);
  assign g4094_data = (state == S_SHIFT_LO || state == S_SHIFT_HI) & sh_reg[NBITS-1];
  assign g4094_strb = (state == S_STROBE);
  assign g4094_oe   = oe_q;
  assign dbg_state  = state;

`ifdef GLB_4094_READBACK_EN
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] prev_word;
  logic [NBITS-1:0] rb_sh;
  logic [NBITS-1:0] rb_q;
  logic             had_prev;
  logic             mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      prev_word <= '0;
      rb_sh     <= '0;
      rb_q      <= '0;
      had_prev  <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      if (accept) shadow <= load_word;
      // End of the low phase: the chain's last stage still shows the bit
      // that was there before this shift clock edge.
      if (state == S_SHIFT_LO && cnt_last) rb_sh <= {rb_sh[NBITS-2:0], miso};
      if (state == S_FIN) begin
        rb_q      <= rb_sh;
        mis_q     <= had_prev && (rb_sh != prev_word);
        prev_word <= shadow;
        had_prev  <= 1'b1;
      end
    end
  end

  assign rb_data  = rb_q;
  assign mismatch = mis_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rb_data     = '0;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_glb_4094_sequencer.sv
module tb_glb_4094_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data;
  logic       oe_en;
  logic       miso;
  logic       busy;
  logic       done;
  logic       g4094_clk;
  logic       g4094_data;
  logic       g4094_strb;
  logic       g4094_oe;
  logic [7:0] rb_data;
  logic       mismatch;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  glb_4094_sequencer #(.NBITS(8), .CLK_DIV(2), .STROBE_CYCLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data       (data),
    .oe_en      (oe_en),
    .miso       (miso),
    .busy       (busy),
    .done       (done),
    .g4094_clk  (g4094_clk),
    .g4094_data (g4094_data),
    .g4094_strb (g4094_strb),
    .g4094_oe   (g4094_oe),
    .rb_data    (rb_data),
    .mismatch   (mismatch),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- 8-bit 4094 chain model ----------------
  logic [7:0] chain    = 8'h00;
  logic [7:0] latch    = 8'h00;
  logic [7:0] bit_log  = 8'h00;
  logic       flip_req = 1'b0;
  int         n_rise   = 0;
  int         strb_cnt = 0;
  int         strb_data_bad = 0;

  always @(posedge g4094_clk or posedge flip_req) begin
    if (flip_req) begin
      chain = chain ^ 8'h01;
    end else begin
      chain   = {chain[6:0], g4094_data};
      bit_log = {bit_log[6:0], g4094_data};
      n_rise++;
    end
  end

  always @(posedge clk) begin
    if (g4094_strb === 1'b1) latch = chain;
  end

  assign miso = chain[7];

  always @(negedge clk) begin
    if (g4094_strb === 1'b1) begin
      strb_cnt++;
      if (g4094_data !== 1'b0) strb_data_bad++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_done", 64'd1, 64'd0);
      else                   check("sb_latch", latch, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the following posedge is the accept edge and the
  // task returns at the negedge of cycle 0 of the transfer.
  task automatic do_start(input logic [7:0] w);
    start = 1'b1;
    data  = w;
    @(negedge clk);
    start = 1'b0;
    data  = 8'h00;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- stimulus ----------------
  int cyc, n0, r0, dc, d1, d2, d3, busy_low;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    data  = 8'h00;
    oe_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", {busy, done, g4094_clk, g4094_data, g4094_strb, g4094_oe,
                         mismatch, rb_data, dbg_state}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("oe_after_reset", g4094_oe, 1'b0);

    // Test 1/2: single transfer of A5, OE gating
    n0 = strb_cnt;
    r0 = n_rise;
    exp_q.push_back(8'hA5);
    do_start(8'hA5);
    check("t1_busy", busy, 1'b1);
    check("t1_first_bit", g4094_data, 1'b1);
    wait_done(60, cyc);
    check("t1_done_cycle", cyc, 35);
    check("t1_oe_at_done", g4094_oe, 1'b0);
    check("t1_strb_cycles", strb_cnt - n0, 3);
    check("t1_rise_count", n_rise - r0, 8);
    check("t1_bits", bit_log, 8'hA5);
    @(negedge clk);
    check("t2_oe_on", g4094_oe, 1'b1);
    check("t1_busy_fall", busy, 1'b0);
    check("t1_mismatch", mismatch, 1'b0);
    oe_en = 1'b0;
    @(negedge clk);
    check("t2_oe_off", g4094_oe, 1'b0);
    oe_en = 1'b1;
    @(negedge clk);
    check("t2_oe_back", g4094_oe, 1'b1);

    // Test 3: starts while busy, latest pending word wins
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h0F);
    do_start(8'h3C);
    dc = 0; d1 = -1; d2 = -1; busy_low = 0;
    for (int i = 0; i < 80; i++) begin
      if (done === 1'b1) begin
        if (dc == 0) d1 = i;
        else if (dc == 1) d2 = i;
        dc++;
      end
      if (busy !== 1'b1 && dc < 2) busy_low++;
      start = (i == 3) || (i == 10);
      data  = (i == 3) ? 8'h11 : ((i == 10) ? 8'h0F : 8'h00);
      @(negedge clk);
    end
    start = 1'b0;
    check("t3_done_count", dc, 2);
    check("t3_done1_cycle", d1, 35);
    check("t3_done2_cycle", d2, 71);
    check("t3_busy_gap", busy_low, 0);
    check("t3_idle_after", busy, 1'b0);

    // Test 4: reset during bit 4 of FF
    n0 = strb_cnt;
    do_start(8'hFF);
    repeat (17) @(negedge clk);
    check("t4_mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_reset_outs", {busy, done, g4094_clk, g4094_data, g4094_strb, g4094_oe,
                            mismatch, rb_data, dbg_state}, 64'd0);
    repeat (3) @(negedge clk);
    check("t4_no_strobe", strb_cnt - n0, 0);
    check("t4_latch_kept", latch, 8'h0F);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_oe_cleared", g4094_oe, 1'b0);
    exp_q.push_back(8'h81);
    do_start(8'h81);
    wait_done(60, cyc);
    check("t4_done_cycle", cyc, 35);
    @(negedge clk);
    check("t4_oe_on", g4094_oe, 1'b1);

    // Test 5: readback with the chain looped to miso
    exp_q.push_back(8'hA5);
    do_start(8'hA5);
    wait_done(60, cyc);
    @(negedge clk);
`ifdef GLB_4094_READBACK_EN
    check("t5_rb_1", rb_data, 8'h81);
`else
    check("t5_rb_1", rb_data, 8'h00);
`endif
    check("t5_mis_1", mismatch, 1'b0);
    exp_q.push_back(8'h5A);
    do_start(8'h5A);
    wait_done(60, cyc);
    @(negedge clk);
`ifdef GLB_4094_READBACK_EN
    check("t5_rb_2", rb_data, 8'hA5);
`else
    check("t5_rb_2", rb_data, 8'h00);
`endif
    check("t5_mis_2", mismatch, 1'b0);
    flip_req = 1'b1;
    #1 flip_req = 1'b0;
    exp_q.push_back(8'hC3);
    do_start(8'hC3);
    wait_done(60, cyc);
    @(negedge clk);
`ifdef GLB_4094_READBACK_EN
    check("t5_rb_3", rb_data, 8'h5B);
    check("t5_mis_3", mismatch, 1'b1);
`else
    check("t5_rb_3", rb_data, 8'h00);
    check("t5_mis_3", mismatch, 1'b0);
`endif

    // Test 6: start held high, back-to-back transfers
    n0 = strb_cnt;
    repeat (4) exp_q.push_back(8'h96);
    start = 1'b1;
    data  = 8'h96;
    @(negedge clk);
    dc = 0; d1 = -1; d2 = -1; d3 = -1; busy_low = 0;
    for (int i = 0; i < 108; i++) begin
      if (done === 1'b1) begin
        if (dc == 0) d1 = i;
        else if (dc == 1) d2 = i;
        else if (dc == 2) d3 = i;
        dc++;
      end
      if (busy !== 1'b1) busy_low++;
      if (i == 107) start = 1'b0;
      @(negedge clk);
    end
    check("t6_done_count", dc, 3);
    check("t6_done1_cycle", d1, 35);
    check("t6_done2_cycle", d2, 71);
    check("t6_done3_cycle", d3, 107);
    check("t6_busy_gap", busy_low, 0);
    cyc = 108;
    while (busy === 1'b1 && cyc < 250) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_idle_cycle", cyc, 144);
    check("t6_strb_cycles", strb_cnt - n0, 12);

    check("strb_data_zero", strb_data_bad, 0);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
